multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Main controller for the multicycle RV32I-subset datapath; drives the ALU's ALU_FUN port (3-bit code).
//  Moore FSM sequences fetch/decode/execute; an ALU-decoder stage turns ALUOp+funct bits into ALU_FUN.
//  Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.
// PARAMETERS
//  STRICT_DECODE  1  1: unsupported opcode/funct3 -> FAULT state (held until RST); 0: treat as no-op, return to FETCH
// PORTS
//  CLK         in   1  system clock, rising edge
//  RST         in   1  asynchronous, active-high reset
//  OPCODE      in   7  instr[6:0] from instruction register
//  FUNCT3      in   3  instr[14:12]
//  FUNCT7_5    in   1  instr[30]
//  ALU_ZERO    in   1  ALU zero flag (same-cycle, combinational)
//  PC_WRITE    out  1  PC register load enable
//  ADR_SRC     out  1  memory address mux: 0=PC, 1=ALU result reg
//  MEM_WRITE   out  1  data memory write strobe
//  IR_WRITE    out  1  instruction register (and OldPC) load enable
//  REG_WRITE   out  1  register file write enable
//  RESULT_SRC  out  2  result mux: 00=ALUOut reg, 01=mem data reg, 10=ALU result
//  ALU_SRC_A   out  2  00=PC, 01=OldPC, 10=rs1 reg
//  ALU_SRC_B   out  2  00=rs2 reg, 01=ImmExt, 10=const 4
//  IMM_SRC     out  2  00=I, 01=S, 10=B, 11=J (combinational from OPCODE)
//  ALU_FUN     out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  FAULT       out  1  high while in FAULT state
// BEHAVIOUR
//  Reset: state<=FETCH asynchronously; while RST=1 all strobes 0, muxes 0, ALU_FUN=000, FAULT=0.
//  Outputs are Moore (decoded from state) except PC_WRITE = PCUpdate | (Branch & ALU_ZERO), IMM_SRC.
//  States/outputs (unlisted = 0; ALUOp 00=add, 01=sub, 10=funct):
//   FETCH:    ADR_SRC=0, IR_WRITE=1, A=00, B=10, ALUOp=00, RESULT_SRC=10, PCUpdate -> DECODE
//   DECODE:   A=01, B=01, ALUOp=00 -> lw/sw:MEMADR, R:EXECR, I-ALU:EXECI, jal:JAL, beq:BEQ, else FAULT/FETCH
//   MEMADR:   A=10, B=01, ALUOp=00 -> lw:MEMREAD, sw:MEMWRITE
//   MEMREAD:  RESULT_SRC=00, ADR_SRC=1 -> MEMWB;  MEMWB: RESULT_SRC=01, REG_WRITE=1 -> FETCH
//   MEMWRITE: RESULT_SRC=00, ADR_SRC=1, MEM_WRITE=1 -> FETCH
//   EXECR:    A=10, B=00, ALUOp=10 -> ALUWB;  EXECI: A=10, B=01, ALUOp=10 -> ALUWB
//   ALUWB:    RESULT_SRC=00, REG_WRITE=1 -> FETCH
//   JAL:      A=01, B=10, ALUOp=00, RESULT_SRC=00, PCUpdate -> ALUWB
//   BEQ:      A=10, B=00, ALUOp=01, RESULT_SRC=00, Branch -> FETCH
//   FAULT:    all strobes 0, FAULT=1; exits only via RST
//  ALU decode: ALUOp 00->000, 01->001; 10: funct3 000 -> 001 if {OPCODE[5],FUNCT7_5}==2'b11 else 000;
//   010->101, 110->011, 111->010; any other funct3 is unsupported (DECODE routes per STRICT_DECODE).
//  beq requires FUNCT3=000; other branch funct3 unsupported.
//  Cycles per instr: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
//  Opcode/funct are sampled from IR, which only changes in FETCH; FSM never stalls.
//  RST mid-instruction: immediate return to FETCH; no partial MEM_WRITE/REG_WRITE pulse after RST rises.
// STRUCTURE
//  ctrl_pkg: state enum (FETCH..FAULT), ALU_FUN code localparams, opcode localparams, mux select encodings.
//  One sub-module: alu_decoder (ALUOp, FUNCT3, OPCODE[5], FUNCT7_5 -> ALU_FUN, unsupported flag); pure comb.
//  Top: always_ff state register (async RST), always_comb next-state + output decode.
// TESTING
//  RST pulse mid-MEMWRITE -> MEM_WRITE drops with RST; after release, FETCH with IR_WRITE=1, PC_WRITE=1.
//  R-type sub (OPCODE=0110011, F3=000, F7_5=1) -> FETCH,DECODE,EXECR(ALU_FUN=001),ALUWB(REG_WRITE=1).
//  addi with F7_5=1 (OPCODE=0010011) -> EXECI ALU_FUN=000, not sub; slti F3=010 -> ALU_FUN=101.
//  lw (0000011) -> 5 cycles, REG_WRITE only in MEMWB with RESULT_SRC=01; sw -> MEM_WRITE=1 for exactly 1 cycle.
//  beq: ALU_ZERO=1 in BEQ -> PC_WRITE=1, ALU_FUN=001; ALU_ZERO=0 -> PC_WRITE=0; next state FETCH both cases.
//  OPCODE=1110011, STRICT_DECODE=1 -> FAULT=1, held 20 cycles, strobes 0; =0 -> back to FETCH after DECODE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset controller.
// Covers FSM states, ALU codes, opcodes and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BEQ,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_for(input logic [6:0] opcode);
        case (opcode)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Turns the controller's ALUOp plus instruction funct bits into the ALU_FUN code.
// The unsupported flag depends only on funct3 so DECODE can use it before ALUOp selects funct.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       opcode_5,
    input  logic       funct7_5,
    output logic [2:0] alu_fun,
    output logic       unsupported
);

    logic [2:0] funct_code;

    // funct7[5] selects sub only for R-type; I-type reuses that bit as immediate.
    always_comb begin
        funct_code  = ALU_ADD;
        unsupported = 1'b0;
        case (funct3)
            F3_ADD:  funct_code = (opcode_5 & funct7_5) ? ALU_SUB : ALU_ADD;
            F3_SLT:  funct_code = ALU_SLT;
            F3_OR:   funct_code = ALU_OR;
            F3_AND:  funct_code = ALU_AND;
            default: unsupported = 1'b1;
        endcase

        case (alu_op)
            ALUOP_SUB:   alu_fun = ALU_SUB;
            ALUOP_FUNCT: alu_fun = funct_code;
            default:     alu_fun = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM controller for the multicycle RV32I-subset datapath.
// All outputs are forced to zero while RST is high so no strobe survives a reset.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter bit STRICT_DECODE = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNCT3,
    input  logic       FUNCT7_5,
    input  logic       ALU_ZERO,
    output logic       PC_WRITE,
    output logic       ADR_SRC,
    output logic       MEM_WRITE,
    output logic       IR_WRITE,
    output logic       REG_WRITE,
    output logic [1:0] RESULT_SRC,
    output logic [1:0] ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [1:0] IMM_SRC,
    output logic [2:0] ALU_FUN,
    output logic       FAULT
);

    state_t     state, next_state;
    alu_op_t    alu_op;
    logic       pc_update, branch;
    logic       adr_src, mem_write, ir_write, reg_write, fault;
    logic [1:0] result_src, src_a, src_b;
    logic [2:0] dec_alu_fun;
    logic       funct_unsupported;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (FUNCT3),
        .opcode_5    (OPCODE[5]),
        .funct7_5    (FUNCT7_5),
        .alu_fun     (dec_alu_fun),
        .unsupported (funct_unsupported)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        alu_op     = ALUOP_ADD;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        fault      = 1'b0;
        result_src = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_RS2;

        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_update  = 1'b1;
                next_state = S_DECODE;
            end
            // Unsupported encodings either lock up in FAULT or are skipped as no-ops.
            S_DECODE: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (OPCODE)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:   next_state = funct_unsupported ? (STRICT_DECODE ? S_FAULT : S_FETCH) : S_EXECR;
                    OP_I:   next_state = funct_unsupported ? (STRICT_DECODE ? S_FAULT : S_FETCH) : S_EXECI;
                    OP_JAL: next_state = S_JAL;
                    OP_BEQ: next_state = (FUNCT3 == F3_BEQ) ? S_BEQ : (STRICT_DECODE ? S_FAULT : S_FETCH);
                    default: next_state = STRICT_DECODE ? S_FAULT : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                next_state = (OPCODE == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_EXECR: begin
                src_a      = SRCA_RS1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                src_a      = SRCA_OLDPC;
                src_b      = SRCB_FOUR;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            S_BEQ: begin
                src_a      = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            S_FAULT: begin
                fault      = 1'b1;
                next_state = S_FAULT;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign PC_WRITE   = ~RST & (pc_update | (branch & ALU_ZERO));
    assign ADR_SRC    = ~RST & adr_src;
    assign MEM_WRITE  = ~RST & mem_write;
    assign IR_WRITE   = ~RST & ir_write;
    assign REG_WRITE  = ~RST & reg_write;
    assign FAULT      = ~RST & fault;
    assign RESULT_SRC = RST ? RES_ALUOUT : result_src;
    assign ALU_SRC_A  = RST ? SRCA_PC : src_a;
    assign ALU_SRC_B  = RST ? SRCB_RS2 : src_b;
    assign IMM_SRC    = RST ? IMM_I : imm_src_for(OPCODE);
    assign ALU_FUN    = RST ? ALU_ADD : dec_alu_fun;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed table, corner sequences and
// random instruction streams against an instruction-level behavioural model.
module tb_multicycle_control_unit;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_BAD = 6;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_fun;
        logic       fault;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         cycles;
        logic [2:0] exec_alu;
        string      name;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [6:0] OPCODE = '0;
    logic [2:0] FUNCT3 = '0;
    logic FUNCT7_5 = 1'b0;
    logic ALU_ZERO = 1'b0;

    logic pc_write, adr_src, mem_write, ir_write, reg_write, fault;
    logic [1:0] result_src, src_a, src_b, imm_src;
    logic [2:0] alu_fun;
    logic pc_write_l, adr_src_l, mem_write_l, ir_write_l, reg_write_l, fault_l;
    logic [1:0] result_src_l, src_a_l, src_b_l, imm_src_l;
    logic [2:0] alu_fun_l;

    ctl_t act, act_lax;
    int n_checks = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    multicycle_control_unit #(.STRICT_DECODE(1'b1)) dut (
        .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7_5(FUNCT7_5),
        .ALU_ZERO(ALU_ZERO), .PC_WRITE(pc_write), .ADR_SRC(adr_src), .MEM_WRITE(mem_write),
        .IR_WRITE(ir_write), .REG_WRITE(reg_write), .RESULT_SRC(result_src),
        .ALU_SRC_A(src_a), .ALU_SRC_B(src_b), .IMM_SRC(imm_src), .ALU_FUN(alu_fun),
        .FAULT(fault)
    );

    multicycle_control_unit #(.STRICT_DECODE(1'b0)) dut_lax (
        .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7_5(FUNCT7_5),
        .ALU_ZERO(ALU_ZERO), .PC_WRITE(pc_write_l), .ADR_SRC(adr_src_l), .MEM_WRITE(mem_write_l),
        .IR_WRITE(ir_write_l), .REG_WRITE(reg_write_l), .RESULT_SRC(result_src_l),
        .ALU_SRC_A(src_a_l), .ALU_SRC_B(src_b_l), .IMM_SRC(imm_src_l), .ALU_FUN(alu_fun_l),
        .FAULT(fault_l)
    );

    assign act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                  src_a, src_b, imm_src, alu_fun, fault};
    assign act_lax = {pc_write_l, adr_src_l, mem_write_l, ir_write_l, reg_write_l, result_src_l,
                      src_a_l, src_b_l, imm_src_l, alu_fun_l, fault_l};

    function automatic int kindOf(input logic [6:0] op, input logic [2:0] f3);
        bit f3_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
        case (op)
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b0110011: return f3_ok ? K_R : K_BAD;
            7'b0010011: return f3_ok ? K_I : K_BAD;
            7'b1100011: return (f3 == 3'd0) ? K_BEQ : K_BAD;
            7'b1101111: return K_JAL;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic int instrCycles(input int kind, input bit strict);
        case (kind)
            K_LW:    return 5;
            K_BEQ:   return 3;
            K_BAD:   return strict ? 1000 : 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] aluFor(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (op[5] && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] immFor(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Expected outputs for the given cycle of an instruction, counted from its fetch.
    function automatic ctl_t modelOut(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                      input logic zero, input int step_in, input bit strict);
        ctl_t o = '0;
        int kind = kindOf(op, f3);
        int step = step_in % instrCycles(kind, strict);
        o.imm_src = immFor(op);
        if (step == 0) begin
            o.pc_write = 1'b1; o.ir_write = 1'b1; o.src_b = 2'b10; o.result_src = 2'b10;
        end else if (step == 1) begin
            o.src_a = 2'b01; o.src_b = 2'b01;
        end else if (kind == K_BAD) begin
            o.fault = 1'b1;
        end else begin
            case (kind)
                K_LW, K_SW: begin
                    if (step == 2) begin o.src_a = 2'b10; o.src_b = 2'b01; end
                    else if (step == 3) begin o.adr_src = 1'b1; o.mem_write = (kind == K_SW); end
                    else begin o.result_src = 2'b01; o.reg_write = 1'b1; end
                end
                K_R, K_I: begin
                    if (step == 2) begin
                        o.src_a = 2'b10; o.src_b = (kind == K_I) ? 2'b01 : 2'b00;
                        o.alu_fun = aluFor(op, f3, f7);
                    end else o.reg_write = 1'b1;
                end
                K_JAL: begin
                    if (step == 2) begin o.src_a = 2'b01; o.src_b = 2'b10; o.pc_write = 1'b1; end
                    else o.reg_write = 1'b1;
                end
                default: begin
                    o.src_a = 2'b10; o.alu_fun = 3'b001; o.pc_write = zero;
                end
            endcase
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic zero);
        OPCODE = op; FUNCT3 = f3; FUNCT7_5 = f7; ALU_ZERO = zero;
    endtask

    task automatic doReset();
        RST = 1'b1;
        #1;
        checkOutput("reset outputs", act, '0);
        checkOutput("reset outputs lax", act_lax, '0);
        @(posedge CLK); #1;
        checkOutput("reset held across edge", act, '0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
    endtask

    // Runs one supported instruction from FETCH, checking every cycle; stops at next fetch.
    task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic zero, input string tag,
                            output int seen, output logic [2:0] exec_alu);
        seen = 12;
        exec_alu = 3'b000;
        applyStimulus(op, f3, f7, zero);
        for (int s = 0; s < 12; s++) begin
            #1;
            if (s > 0 && act.ir_write === 1'b1) begin
                seen = s;
                break;
            end
            checkOutput($sformatf("%s step%0d", tag, s), act, modelOut(op, f3, f7, zero, s, 1'b1));
            checkOutput($sformatf("%s lax step%0d", tag, s), act_lax, modelOut(op, f3, f7, zero, s, 1'b0));
            if (s == 2) exec_alu = act.alu_fun;
            @(posedge CLK); #1;
        end
    endtask

    // Unsupported instruction: strict copy must lock in FAULT, lax copy must refetch.
    task automatic runBad(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input int hold, input string tag);
        applyStimulus(op, f3, f7, 1'b0);
        for (int s = 0; s < hold + 2; s++) begin
            #1;
            checkOutput($sformatf("%s step%0d", tag, s), act, modelOut(op, f3, f7, 1'b0, s, 1'b1));
            if (s < 4)
                checkOutput($sformatf("%s lax step%0d", tag, s), act_lax,
                            modelOut(op, f3, f7, 1'b0, s, 1'b0));
            @(posedge CLK); #1;
        end
    endtask

    vec_t vecs[14];
    logic [6:0] valid_ops[6];

    initial begin
        int seen;
        logic [2:0] ex_alu;
        logic [6:0] op;
        logic [2:0] f3;
        logic f7, zero;

        vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b000, "add"};
        vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001, "sub"};
        vecs[2]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 3'b010, "and"};
        vecs[3]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 3'b011, "or"};
        vecs[4]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b101, "slt"};
        vecs[5]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, "addi_f7"};
        vecs[6]  = '{7'b0010011, 3'b111, 1'b0, 1'b0, 4, 3'b010, "andi"};
        vecs[7]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, 4, 3'b101, "slti"};
        vecs[8]  = '{7'b0010011, 3'b110, 1'b1, 1'b0, 4, 3'b011, "ori"};
        vecs[9]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b000, "lw"};
        vecs[10] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3'b000, "sw"};
        vecs[11] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001, "beq_taken"};
        vecs[12] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b001, "beq_not_taken"};
        vecs[13] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 3'b000, "jal"};
        valid_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

        $display("[TB] starting");
        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1);
        doReset();

        foreach (vecs[i]) begin
            runInstr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero, vecs[i].name, seen, ex_alu);
            checkOutput({vecs[i].name, " cycles"}, seen, vecs[i].cycles);
            checkOutput({vecs[i].name, " exec alu_fun"}, {29'd0, ex_alu}, {29'd0, vecs[i].exec_alu});
        end

        // Reset pulse while the store strobe is active.
        doReset();
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("sw mem_write before reset", {31'd0, act.mem_write}, 32'd1);
        RST = 1'b1;
        #1;
        checkOutput("mem_write drops with reset", {31'd0, act.mem_write}, 32'd0);
        checkOutput("all outputs zero in reset", act, '0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checkOutput("fetch after reset ir_write", {31'd0, act.ir_write}, 32'd1);
        checkOutput("fetch after reset pc_write", {31'd0, act.pc_write}, 32'd1);
        checkOutput("fetch after reset outputs", act, modelOut(OPCODE, FUNCT3, FUNCT7_5, ALU_ZERO, 0, 1'b1));

        // System opcode: strict holds FAULT for 20 cycles, lax returns to fetch.
        doReset();
        runBad(7'b1110011, 3'b000, 1'b0, 20, "ecall");
        checkOutput("fault flag held", {31'd0, act.fault}, 32'd1);
        doReset();
        runBad(7'b1100011, 3'b001, 1'b0, 3, "bne");
        doReset();
        runBad(7'b0110011, 3'b001, 1'b0, 3, "sll");

        doReset();
        for (int n = 0; n < 150; n++) begin
            op = valid_ops[$urandom_range(0, 5)];
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
            if (kindOf(op, f3) == K_BAD) begin
                runBad(op, f3, f7, 3, $sformatf("rand%0d bad", n));
                doReset();
            end else begin
                runInstr(op, f3, f7, zero, $sformatf("rand%0d", n), seen, ex_alu);
                checkOutput($sformatf("rand%0d cycles", n), seen, instrCycles(kindOf(op, f3), 1'b1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
